// File: rtl/mem_byte_master.sv
// mem_byte_master
//   Byte-wide data memory initiator for the CPU memory stage. One load or
//   store is accepted per handshake. The access is split into 1, 2 or 4
//   sequential byte transfers, most significant byte first. Read bytes are
//   reassembled into a 32-bit result with sign or zero extension.
//   Alignment and size checks are done here.
//
// Ports
//   CLK, Reset          clock, synchronous active-low reset
//   req_*               request handshake (valid/ready) and request fields
//   rsp_valid/rdata/err one-cycle completion pulse with load data / error flag
//   mem_en/we/addr/wdata byte transfer strobe towards the memory
//   mem_rdata           read byte, returned one cycle after a read strobe
module mem_byte_master #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_RESP} state_t;

  state_t      r_state;
  logic [1:0]  r_k;       // index of the transfer currently on the bus
  logic [1:0]  r_nm1;     // transfer count minus one (0, 1 or 3)
  logic        r_we;
  logic        r_signed;
  logic [31:0] r_wsh;     // store bytes still to send, next one in [31:24]
  logic [23:0] r_rsh;     // read bytes collected so far, newest in [7:0]

  logic        w_accept;
  logic        w_err;
  logic [1:0]  w_nm1;
  logic [4:0]  w_wshamt;
  logic [31:0] w_wsh_init;
  logic [31:0] w_asm;
  logic [31:0] w_ext;

  assign req_ready = (r_state == S_IDLE) && Reset;
  assign w_accept  = req_valid && req_ready;

  assign w_err = (req_size == 2'b11) ||
                 ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    w_nm1 = 2'd0;
    case (req_size)
      2'b01:   w_nm1 = 2'd1;
      2'b10:   w_nm1 = 2'd3;
      default: w_nm1 = 2'd0;
    endcase
  end

  // Left-justify the store data so the big-endian first byte sits in [31:24];
  // each transfer then just takes the top byte and shifts.
  assign w_wshamt   = {2'd3 - w_nm1, 3'b000};
  assign w_wsh_init = req_wdata << w_wshamt;

  // Final assembled value: shifting bytes in from the bottom leaves the
  // first-transferred byte highest, which is exactly the big-endian order.
  // Unused upper bytes stay zero because r_rsh is cleared on accept.
  assign w_asm = {r_rsh, mem_rdata};

  always_comb begin
    w_ext = w_asm;
    case (r_nm1)
      2'd0:    w_ext = {{24{r_signed & w_asm[7]}},  w_asm[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_asm[15]}}, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_k       <= 2'd0;
      r_nm1     <= 2'd0;
      r_we      <= 1'b0;
      r_signed  <= 1'b0;
      r_wsh     <= 32'd0;
      r_rsh     <= 24'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
          if (w_accept) begin
            r_we     <= req_we;
            r_signed <= req_signed;
            r_nm1    <= w_nm1;
            r_k      <= 2'd0;
            r_rsh    <= 24'd0;
            if (w_err) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              // first transfer is launched straight from the request
              r_state   <= S_XFER;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr;
              mem_wdata <= w_wsh_init[31:24];
              r_wsh     <= w_wsh_init << 8;
            end
          end
        end

        S_XFER: begin
          // byte for the previous strobe is on mem_rdata now
          if (!r_we && (r_k != 2'd0))
            r_rsh <= {r_rsh[15:0], mem_rdata};
          if (r_k == r_nm1) begin
            mem_en <= 1'b0;
            if (r_we) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'd0;
              rsp_err   <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_k       <= r_k + 2'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);  // wraps at ADDR_W bits
            mem_wdata <= r_wsh[31:24];
            r_wsh     <= r_wsh << 8;
          end
        end

        S_DRAIN: begin
          r_rsh     <= w_asm[23:0];
          r_state   <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= w_ext;
          rsp_err   <= 1'b0;
        end

        S_RESP: begin
          r_state   <= S_IDLE;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_master.sv
// Bench for mem_byte_master: a byte memory responder, a cycle-indexed
// expectation table built from the access rules, a per-cycle compare
// process, directed cases with literal results, then randomized traffic.
module tb_mem_byte_master;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;

  mem_byte_master #(.ADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    bit          en;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  wd;
    bit          rv;
    logic [31:0] rd;
    bit          err;
  } exp_t;

  exp_t       exp_q[int];
  logic [7:0] dev_mem[logic [31:0]];
  logic [7:0] ref_mem[logic [31:0]];

  int   cyc = 0;
  int   busy_until = -1;
  int   nvec = 0;
  int   nerr = 0;
  bit   chk_on = 1'b0;
  int   last_acc = 0;
  int   last_rsp = 0;
  int   rsp_cnt = 0;
  logic [31:0] last_rd = 32'd0;
  logic        last_err = 1'b0;
  int   rsp_cyc_q[$];

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_ref(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  // memory device: writes land at the edge, read data appears next cycle
  always @(posedge CLK) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) dev_mem[mem_addr] = mem_wdata;
    if (mem_en === 1'b1 && mem_we === 1'b0)
      mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_byte(mem_addr);
    else
      mem_rdata <= 8'($urandom);
  end

  // Reference model: on accept, schedule every bus cycle and the response.
  function automatic void model_accept(int t);
    int n;
    bit err;
    int r;
    logic [31:0] v;
    exp_t e;
    n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
    err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    last_acc = t;
    if (err) begin
      e = '0; e.rv = 1'b1; e.err = 1'b1; e.rd = 32'd0;
      exp_q[t+1] = e;
      busy_until = t + 1;
      return;
    end
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      e = '0;
      e.en = 1'b1;
      e.we = req_we;
      e.addr = req_addr + 32'(k);
      e.wd = 8'(req_wdata >> (8 * (n - 1 - k)));
      exp_q[t+1+k] = e;
      if (!req_we) v = (v << 8) | 32'(rd_ref(req_addr + 32'(k)));
    end
    if (!req_we && req_signed) begin
      if (n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
    end
    r = t + n + 1 + (req_we ? 0 : 1);
    e = '0; e.rv = 1'b1; e.rd = req_we ? 32'd0 : v;
    exp_q[r] = e;
    busy_until = r;
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    if (exp_q.exists(cyc)) begin
      e = exp_q[cyc];
      if (e.en && e.we) ref_mem[e.addr] = e.wd;
    end
    if (!Reset) begin
      for (int i = 1; i <= 8; i++)
        if (exp_q.exists(cyc + i)) exp_q.delete(cyc + i);
      busy_until = cyc;
    end else if (req_valid && req_ready) begin
      model_accept(cyc);
    end
    cyc++;
  end

  // per-cycle compare against the expectation table
  always @(negedge CLK) begin
    exp_t e;
    if (chk_on) begin
      e = '0;
      if (exp_q.exists(cyc)) e = exp_q[cyc];
      chk("mem_en", 32'(mem_en), 32'(e.en));
      if (e.en) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
      if (e.rv) begin
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      chk("req_ready", 32'(req_ready), 32'(Reset && (cyc > busy_until)));
      if (rsp_valid === 1'b1) begin
        last_rsp = cyc;
        last_rd = rsp_rdata;
        last_err = rsp_err;
        rsp_cnt++;
        rsp_cyc_q.push_back(cyc);
      end
    end
  end

  // called at posedge+#1; returns at posedge+#1 after accept (or response)
  task automatic do_req(bit we, logic [1:0] sz, bit sg, logic [31:0] a,
                        logic [31:0] wd, bit wait_r);
    int c0;
    bit ok;
    c0 = rsp_cnt;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (req_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    if (wait_r) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (rsp_cnt != c0) begin ok = 1'b1; break; end
        @(posedge CLK);
      end
      #1;
      if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    int c0;
    int s0;
    bit abort;
    logic [1:0]  sz;
    logic [31:0] a;

    Reset = 1'b0;
    @(posedge CLK); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;

    // word store / load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b1);
    chk("st_w_lat", 32'(last_rsp - last_acc), 32'd5);
    chk("st_w_err", 32'(last_err), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);
    chk("ld_w_lat", 32'(last_rsp - last_acc), 32'd6);
    chk("ld_w_data", last_rd, 32'h1122_3344);

    // halfword/byte extension
    do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_8001, 1'b1);
    chk("st_h_lat", 32'(last_rsp - last_acc), 32'd3);
    do_req(1'b1, 2'd0, 1'b0, 32'h23, 32'h0000_00F0, 1'b1);
    chk("st_b_lat", 32'(last_rsp - last_acc), 32'd2);
    do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'd0, 1'b1);
    chk("ld_hs_data", last_rd, 32'hFFFF_8001);
    chk("ld_h_lat", 32'(last_rsp - last_acc), 32'd4);
    do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 1'b1);
    chk("ld_hu_data", last_rd, 32'h0000_8001);
    do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'd0, 1'b1);
    chk("ld_bs_data", last_rd, 32'hFFFF_FFF0);
    chk("ld_b_lat", 32'(last_rsp - last_acc), 32'd3);

    // misalignment and illegal size
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'd0, 1'b1);
    chk("mis_w_err", 32'(last_err), 32'd1);
    chk("mis_w_rd", last_rd, 32'd0);
    chk("mis_w_lat", 32'(last_rsp - last_acc), 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF, 1'b1);
    chk("mis_h_err", 32'(last_err), 32'd1);
    chk("mis_h_lat", 32'(last_rsp - last_acc), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 1'b1);
    chk("ill_sz_err", 32'(last_err), 32'd1);
    chk("ill_sz_rd", last_rd, 32'd0);

    // address wrap
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hAABB_CCDD, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b1);
    chk("wrap_data", last_rd, 32'hAABB_CCDD);

    // reset during the second strobe of a word store
    c0 = rsp_cnt;
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h5566_7788, 1'b0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(negedge CLK);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (6) @(posedge CLK);
    #1;
    chk("abort_no_rsp", 32'(rsp_cnt), 32'(c0));
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1);
    chk("abort_after_data", last_rd, 32'h5566_1819);
    chk("abort_after_lat", 32'(last_rsp - last_acc), 32'd6);

    // back-to-back byte stores with req_valid held
    s0 = rsp_cyc_q.size();
    do_req(1'b1, 2'd0, 1'b0, 32'h50, 32'h01, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h51, 32'h02, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h52, 32'h03, 1'b0);
    repeat (8) @(posedge CLK);
    #1;
    chk("b2b_count", 32'(rsp_cyc_q.size() - s0), 32'd3);
    if (rsp_cyc_q.size() - s0 == 3) begin
      chk("b2b_gap1", 32'(rsp_cyc_q[s0+1] - rsp_cyc_q[s0]), 32'd3);
      chk("b2b_gap2", 32'(rsp_cyc_q[s0+2] - rsp_cyc_q[s0+1]), 32'd3);
    end

    // randomized traffic with occasional aborts
    for (int it = 0; it < 250; it++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      abort = ($urandom_range(0, 24) == 0);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'h0000_0100) +
          32'($urandom_range(0, 15));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, !abort);
      if (abort) begin
        repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
        Reset = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
      end
    end

    repeat (3) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_byte_master.md
# mem_byte_master

Initiator for the byte-wide data memory port. It accepts one load or store request per handshake from the multi-cycle CPU's memory stage. Each access is broken into 1, 2 or 4 sequential byte transfers in big-endian order, and the read bytes are reassembled into a 32-bit result with sign or zero extension. It sits between the CPU datapath and the data memory and performs all alignment checking.

## Interface
Parameters:
- ADDR_W, 32, width of request and memory addresses

Ports:
- CLK  in  1  rising-edge clock; the block has one clock
- Reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified for byte and halfword
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request, valid with rsp_valid
- mem_en  out  1  byte transfer strobe
- mem_we  out  1  1 = write byte, 0 = read byte; meaningful only when mem_en=1
- mem_addr  out  ADDR_W  byte address of the current transfer
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, returned exactly 1 cycle after a read strobe

## Operation
- State machine: IDLE, XFER, DRAIN, RESP.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready, latch we, size, signed, addr and wdata.
  - Set N=1/2/4 for size 00/01/10.
  - Error cases:
    - size=11 → err.
    - Halfword with addr[0]=1 → err.
    - Word with addr[1:0]≠0 → err.
  - On err, go to RESP with err=1. Otherwise go to XFER with counter k=0.
- XFER
  - Each cycle: mem_en=1, mem_we=we, mem_addr=addr+k (ADDR_W-bit wrap), k++.
  - Leave when k reaches N-1: stores go to RESP, loads go to DRAIN.
- Big-endian byte mapping:
  - Transfer k carries value byte N-1-k: word k=0→[31:24] … k=3→[7:0]; halfword k=0→[15:8], k=1→[7:0]; byte k=0→[7:0].
  - The same mapping applies to mem_wdata and to reassembly of mem_rdata.
- Loads: mem_rdata is captured the cycle after each strobe, into the byte lane given by the transfer index. DRAIN lasts one cycle and captures the final byte.
- RESP
  - rsp_valid=1 for one cycle.
  - rsp_rdata is the assembled value, extended from bit 7 (byte) or bit 15 (halfword) when signed=1, otherwise zero-filled. Word results are unextended.
  - Then return to IDLE.
- Responses have no backpressure, and only one request is outstanding at a time.

## Timing
- Reset (Reset=0 at a CLK edge) forces:
  - state=IDLE, k=0
  - rsp_valid=0, rsp_err=0, rsp_rdata=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - req_ready=0 while Reset=0
- req_ready=1 from the first cycle after Reset returns to 1.
- Reset asserted mid-operation aborts the access: no rsp_valid, and mem_en=0 from the next cycle. Bytes already written stay written.
- Request accepted at edge T:
  - Store: mem_en high in cycles T+1..T+N, rsp_valid in cycle T+N+1 (byte 2, half 3, word 5 cycles).
  - Load: strobes in cycles T+1..T+N, DRAIN in cycle T+N+1, rsp_valid in cycle T+N+2 (byte 3, half 4, word 6).
  - Error: rsp_valid in cycle T+1, mem_en never asserted.
- req_ready=0 from cycle T+1 through the RESP cycle. A new request can be accepted in the cycle after RESP.
- Outputs are registered except req_ready (decoded from state, gated by Reset).
- mem_* change only on CLK edges.

## Test plan
- Word store then word load:
  - Store addr 0x10, data 0x11223344 → writes 0x11,0x22,0x33,0x44 to 0x10..0x13 in consecutive cycles, rsp_valid 5 cycles after accept.
  - Load 0x10 → rsp_rdata=0x11223344, err=0, 6 cycles after accept.
- Halfword load of memory bytes 0x80,0x01 at 0x20:
  - signed=1 → 0xFFFF8001.
  - signed=0 → 0x00008001.
  - Byte load of 0xF0 at 0x23 with signed=1 → 0xFFFFFFF0.
- Misalignment:
  - Word at 0x22 → err=1, rdata=0, rsp_valid at T+1, no mem_en.
  - Halfword at 0x21 → same.
  - size=11 at 0x0 → same.
- Wrap: word load at 0xFFFFFFFC → mem_addr sequence FFFFFFFC..FFFFFFFF, correct assembly.
- Reset mid-access: Reset=0 during the 2nd strobe of a word store → no rsp_valid, mem_en=0 next cycle, req_ready=1 after release, next request completes normally.
- Back-to-back: req_valid held high with 3 queued byte stores → each accepted only in IDLE, 2-cycle spacing of rsp_valid pulses plus one IDLE cycle.
